// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: opcodes, FSM state encoding, memory size codes, opcode classes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The datapath imports the same package so that the state and size encodings seen on the
// control-unit ports have one definition.
package cpu_ctrl_pkg;

    // Opcode map (6-bit instruction opcode field)
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000110;
    localparam logic [5:0] OP_ANDI  = 6'b000111;
    localparam logic [5:0] OP_SUBI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001001;
    localparam logic [5:0] OP_BEQ   = 6'b001010;
    localparam logic [5:0] OP_BNEQ  = 6'b001011;
    localparam logic [5:0] OP_BGEZ  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001101;
    localparam logic [5:0] OP_LH    = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SB    = 6'b010000;
    localparam logic [5:0] OP_SH    = 6'b010001;
    localparam logic [5:0] OP_SW    = 6'b010010;
    localparam logic [5:0] OP_LUI   = 6'b010011;
    localparam logic [5:0] OP_LB    = 6'b010100;
    localparam logic [5:0] OP_J     = 6'b010101;
    localparam logic [5:0] OP_JR    = 6'b010110;
    localparam logic [5:0] OP_JAL   = 6'b010111;

    // FSM state encoding, visible on the state port
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_WB_ALU = 4'd3,
        S_BRANCH = 4'd4,
        S_JUMP   = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM_RD = 4'd7,
        S_MEM_WR = 4'd8,
        S_WB_MEM = 4'd9,
        S_ERR    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    // Opcode classes produced by opcode_class_decode
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_JUMP    = 3'd3,
        CLS_LOAD    = 3'd4,
        CLS_STORE   = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    // mem_read size codes
    localparam logic [1:0] MRD_NONE = 2'b00;
    localparam logic [1:0] MRD_WORD = 2'b01;
    localparam logic [1:0] MRD_HALF = 2'b10;
    localparam logic [1:0] MRD_BYTE = 2'b11;

    // mem_write size codes (note: ordering differs from mem_read)
    localparam logic [1:0] MWR_NONE = 2'b00;
    localparam logic [1:0] MWR_BYTE = 2'b01;
    localparam logic [1:0] MWR_HALF = 2'b10;
    localparam logic [1:0] MWR_WORD = 2'b11;

    // alu_src operand select
    localparam logic [1:0] ASRC_REG = 2'b00;
    localparam logic [1:0] ASRC_IMM = 2'b01;
    localparam logic [1:0] ASRC_BR  = 2'b10;

    // Read size for a load opcode; LUI (and anything else) reads nothing.
    function automatic logic [1:0] load_size(input logic [5:0] op);
        case (op)
            OP_LW:   return MRD_WORD;
            OP_LH:   return MRD_HALF;
            OP_LB:   return MRD_BYTE;
            default: return MRD_NONE;
        endcase
    endfunction

    // Write size for a store opcode.
    function automatic logic [1:0] store_size(input logic [5:0] op);
        case (op)
            OP_SB:   return MWR_BYTE;
            OP_SH:   return MWR_HALF;
            OP_SW:   return MWR_WORD;
            default: return MWR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Classifies an opcode into the instruction class that drives FSM routing.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the opcode input.
//
// Ports: opcode (in, OPCODE_W) -> op_class (out, op_class_t). Unlisted opcodes map to CLS_ILLEGAL.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OPCODE_W'(OP_RTYPE):                    op_class = CLS_RTYPE;
            OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ANDI),
            OPCODE_W'(OP_SUBI), OPCODE_W'(OP_ORI),
            OPCODE_W'(OP_SLTI):                     op_class = CLS_IMM;
            OPCODE_W'(OP_BEQ), OPCODE_W'(OP_BNEQ),
            OPCODE_W'(OP_BGEZ):                     op_class = CLS_BRANCH;
            OPCODE_W'(OP_J), OPCODE_W'(OP_JR),
            OPCODE_W'(OP_JAL):                      op_class = CLS_JUMP;
            OPCODE_W'(OP_LH), OPCODE_W'(OP_LW),
            OPCODE_W'(OP_LUI), OPCODE_W'(OP_LB):    op_class = CLS_LOAD;
            OPCODE_W'(OP_SB), OPCODE_W'(OP_SH),
            OPCODE_W'(OP_SW):                       op_class = CLS_STORE;
            default:                                op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback per instruction.
// Latency: 3 to 5 states per instruction plus mem_ready wait cycles in FETCH/MEM_RD/MEM_WR.
// Backpressure: memory states hold mem_req until mem_ready; MEM_TIMEOUT waits without it -> ERR.
//
// Ports: clk, reset (sync, active-high); opcode, mem_ready in; mem_req, mem_read[1:0],
// mem_write[1:0], alu_src[1:0], alu_op[ALUOP_W-1:0], pc_write, ir_write, reg_dst, jump, branch,
// mem_to_reg, reg_write, instr_done, bus_err, state[3:0] out.
// Build option: define ILLEGAL_TRAP_EN to send unlisted opcodes to a sticky TRAP state with
// bus_err; otherwise they retire immediately back to FETCH with an instr_done pulse.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                jump,
    output logic                branch,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                instr_done,
    output logic                bus_err,
    output logic [1:0]          mem_read,
    output logic [1:0]          mem_write,
    output logic [1:0]          alu_src,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [3:0]          state
);

    state_t              state_q;
    state_t              state_d;
    logic [OPCODE_W-1:0] op_q;
    logic [7:0]          wait_cnt;
    logic [OPCODE_W-1:0] dec_in;
    op_class_t           op_cls;
    logic [5:0]          op6;
    logic                timeout;
    logic                mem_state;
    logic                is_rtype;

    // In DECODE the live opcode is classified for routing; afterwards only the latched copy is
    // used, so the IR may change under us without affecting the instruction in flight.
    assign dec_in = (state_q == S_DECODE) ? opcode : op_q;

    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_cls (
        .opcode   (dec_in),
        .op_class (op_cls)
    );

    assign op6       = 6'(op_q);
    assign is_rtype  = (op_cls == CLS_RTYPE);
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // wait_cnt counts completed wait cycles; this is the last cycle we are willing to wait.
    assign timeout   = (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Any state change clears the counter, so every memory state starts from zero.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (mem_state) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_read   = MRD_NONE;
        mem_write  = MWR_NONE;
        alu_src    = ASRC_REG;
        alu_op     = '0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_read = MRD_WORD;
                // IR/PC update is qualified by mem_ready so it happens exactly once, on the
                // cycle the instruction word is on the bus.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end

            S_DECODE: begin
                case (op_cls)
                    CLS_RTYPE, CLS_IMM:   state_d = S_EXEC;
                    CLS_BRANCH:           state_d = S_BRANCH;
                    CLS_JUMP:             state_d = S_JUMP;
                    CLS_LOAD, CLS_STORE:  state_d = S_ADDR;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
`endif
                    end
                endcase
            end

            S_EXEC: begin
                alu_op  = is_rtype ? '1 : ALUOP_W'(op_q);
                alu_src = is_rtype ? ASRC_REG : ASRC_IMM;
                state_d = S_WB_ALU;
            end

            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = ~is_rtype;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                branch     = 1'b1;
                alu_src    = ASRC_BR;
                alu_op     = ALUOP_W'(op_q);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_JUMP: begin
                jump       = 1'b1;
                pc_write   = 1'b1;
                reg_write  = (op_q == OPCODE_W'(OP_JAL));
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_ADDR: begin
                alu_src = ASRC_IMM;
                alu_op  = ALUOP_W'(OP_ADDI);
                state_d = (op_cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                // LUI shares the load path for writeback but never touches memory.
                if (op_q == OPCODE_W'(OP_LUI)) begin
                    state_d = S_WB_MEM;
                end else begin
                    mem_req  = 1'b1;
                    mem_read = load_size(op6);
                    if (mem_ready) begin
                        state_d = S_WB_MEM;
                    end else if (timeout) begin
                        state_d = S_ERR;
                    end
                end
            end

            S_MEM_WR: begin
                mem_req   = 1'b1;
                mem_write = store_size(op6);
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end

            S_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            // Both error states are sticky until reset.
            S_ERR: begin
                bus_err = 1'b1;
            end

            S_TRAP: begin
                bus_err = 1'b1;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit with an instruction-level reference.
// Latency: n/a.
// Backpressure: mem_ready is withheld for random and boundary wait counts.
module tb_multicycle_control_unit;

    localparam int TMO = 15;

    // Instruction classes used by the reference
    localparam int C_R = 0, C_I = 1, C_B = 2, C_J = 3, C_L = 4, C_S = 5, C_X = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, pc_write, ir_write, reg_dst, jump, branch;
    logic       mem_to_reg, reg_write, instr_done, bus_err;
    logic [1:0] mem_read, mem_write, alu_src;
    logic [5:0] alu_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OPCODE_W    (6),
        .ALUOP_W     (6),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .jump       (jump),
        .branch     (branch),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .instr_done (instr_done),
        .bus_err    (bus_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .state      (state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       req;
        logic [1:0] mrd;
        logic [1:0] mwr;
        logic [1:0] asrc;
        logic [5:0] aop;
        logic       pcw;
        logic       irw;
        logic       rdst;
        logic       jmp;
        logic       br;
        logic       m2r;
        logic       rw;
        logic       done;
        logic       berr;
    } obs_t;

    obs_t obs;
    assign obs = {state, mem_req, mem_read, mem_write, alu_src, alu_op, pc_write, ir_write,
                  reg_dst, jump, branch, mem_to_reg, reg_write, instr_done, bus_err};

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    logic [5:0] legal_ops [0:18];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'd0:                         return C_R;
            6'd6, 6'd7, 6'd8, 6'd9, 6'd13: return C_I;
            6'd10, 6'd11, 6'd12:          return C_B;
            6'd21, 6'd22, 6'd23:          return C_J;
            6'd14, 6'd15, 6'd19, 6'd20:   return C_L;
            6'd16, 6'd17, 6'd18:          return C_S;
            default:                      return C_X;
        endcase
    endfunction

    function automatic logic [1:0] rd_size(input logic [5:0] op);
        case (op)
            6'd15:   return 2'b01;  // LW
            6'd14:   return 2'b10;  // LH
            6'd20:   return 2'b11;  // LB
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] wr_size(input logic [5:0] op);
        case (op)
            6'd16:   return 2'b01;  // SB
            6'd17:   return 2'b10;  // SH
            6'd18:   return 2'b11;  // SW
            default: return 2'b00;
        endcase
    endfunction

    function automatic obs_t idle(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    // One clock cycle: drive inputs just after the falling edge, compare all outputs 1ns later.
    task automatic step(input string tag, input logic [5:0] op, input logic rdy, input logic rst,
                        input obs_t e);
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        reset     = rst;
        #1;
        if (obs.req && obs.st == 4'd7) req_cnt++;
        if (obs.done) done_cnt++;
        check_val(tag, 32'(obs), 32'(e));
    endtask

    function automatic obs_t fetch_exp(input logic got_word);
        obs_t e;
        e = idle(4'd0);
        e.req = 1'b1;
        e.mrd = 2'b01;
        e.irw = got_word;
        e.pcw = got_word;
        return e;
    endfunction

    // Whole instruction from a fresh FETCH: fw wait cycles before the instruction word arrives,
    // mw wait cycles before the data access completes. Outside DECODE the opcode bus carries junk
    // and mem_ready toggles randomly wherever it must be ignored.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        obs_t e;
        int c;
        string t;
        c = cls_of(op);
        t = $sformatf("op%0d", op);
        for (int i = 0; i <= fw; i++) begin
            step({t, "_fetch"}, 6'($urandom), (i == fw), 1'b0, fetch_exp(i == fw));
        end
        e = idle(4'd1);
`ifndef ILLEGAL_TRAP_EN
        if (c == C_X) e.done = 1'b1;
`endif
        step({t, "_decode"}, op, 1'($urandom), 1'b0, e);
        case (c)
            C_R, C_I: begin
                e = idle(4'd2);
                e.asrc = (c == C_R) ? 2'b00 : 2'b01;
                e.aop  = (c == C_R) ? 6'h3f : op;
                step({t, "_exec"}, 6'($urandom), 1'($urandom), 1'b0, e);
                e = idle(4'd3);
                e.rw = 1'b1;
                e.rdst = (c == C_I);
                e.done = 1'b1;
                step({t, "_wbalu"}, 6'($urandom), 1'($urandom), 1'b0, e);
            end
            C_B: begin
                e = idle(4'd4);
                e.br = 1'b1;
                e.asrc = 2'b10;
                e.aop = op;
                e.done = 1'b1;
                step({t, "_branch"}, 6'($urandom), 1'($urandom), 1'b0, e);
            end
            C_J: begin
                e = idle(4'd5);
                e.jmp = 1'b1;
                e.pcw = 1'b1;
                e.rw = (op == 6'd23);
                e.done = 1'b1;
                step({t, "_jump"}, 6'($urandom), 1'($urandom), 1'b0, e);
            end
            C_L, C_S: begin
                e = idle(4'd6);
                e.asrc = 2'b01;
                e.aop = 6'd6;
                step({t, "_addr"}, 6'($urandom), 1'($urandom), 1'b0, e);
                if (op == 6'd19) begin
                    step({t, "_memrd_lui"}, 6'($urandom), 1'($urandom), 1'b0, idle(4'd7));
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        e = idle((c == C_L) ? 4'd7 : 4'd8);
                        e.req = 1'b1;
                        if (c == C_L) e.mrd = rd_size(op);
                        else          e.mwr = wr_size(op);
                        e.done = (c == C_S) && (i == mw);
                        step({t, "_mem"}, 6'($urandom), (i == mw), 1'b0, e);
                    end
                end
                if (c == C_L) begin
                    e = idle(4'd9);
                    e.m2r = 1'b1;
                    e.rw = 1'b1;
                    e.rdst = 1'b1;
                    e.done = 1'b1;
                    step({t, "_wbmem"}, 6'($urandom), 1'($urandom), 1'b0, e);
                end
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                e = idle(4'd11);
                e.berr = 1'b1;
                for (int i = 0; i < 3; i++) step({t, "_trap"}, 6'($urandom), 1'($urandom), 1'b0, e);
`endif
            end
        endcase
    endtask

    // Starves one memory access until the timeout fires, checks ERR is sticky, then resets.
    // op == 0 starves the instruction fetch; otherwise the data access of load/store op.
    task automatic run_timeout(input logic [5:0] op);
        obs_t e;
        int c;
        c = cls_of(op);
        if (op != 6'd0) begin
            step("tmo_fetch", 6'($urandom), 1'b1, 1'b0, fetch_exp(1'b1));
            step("tmo_decode", op, 1'b0, 1'b0, idle(4'd1));
            e = idle(4'd6);
            e.asrc = 2'b01;
            e.aop = 6'd6;
            step("tmo_addr", 6'($urandom), 1'b0, 1'b0, e);
        end
        for (int i = 0; i < TMO; i++) begin
            if (op == 6'd0) begin
                e = fetch_exp(1'b0);
            end else begin
                e = idle((c == C_L) ? 4'd7 : 4'd8);
                e.req = 1'b1;
                if (c == C_L) e.mrd = rd_size(op);
                else          e.mwr = wr_size(op);
            end
            step("tmo_wait", 6'($urandom), 1'b0, 1'b0, e);
        end
        e = idle(4'd10);
        e.berr = 1'b1;
        for (int i = 0; i < 3; i++) step("err_hold", 6'($urandom), 1'b1, 1'b0, e);
        step("err_in_reset", 6'($urandom), 1'b0, 1'b1, e);
        step("err_after_reset", 6'($urandom), 1'b0, 1'b0, fetch_exp(1'b0));
    endtask

    initial begin
        obs_t e;
        logic [5:0] op;
        legal_ops = '{6'd0, 6'd6, 6'd7, 6'd8, 6'd9, 6'd13, 6'd10, 6'd11, 6'd12, 6'd21,
                      6'd22, 6'd23, 6'd14, 6'd15, 6'd19, 6'd20, 6'd16, 6'd17, 6'd18};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        step("rst_state", 6'd0, 1'b0, 1'b0, fetch_exp(1'b0));

        // ADDI, word on first fetch cycle: exactly one instr_done
        done_cnt = 0;
        run_instr(6'd6, 0, 0);
        check_val("addi_done_cnt", done_cnt, 1);

        // LW with data three cycles late: mem_req held four MEM_RD cycles
        req_cnt = 0;
        run_instr(6'd15, 0, 3);
        check_val("lw_req_cycles", req_cnt, 4);

        run_instr(6'd17, 1, 2);           // SH
        run_instr(6'd10, 0, 0);           // BEQ
        run_instr(6'd23, 0, 0);           // JAL
        run_instr(6'd19, 0, 0);           // LUI
        run_instr(6'd6, TMO - 1, 0);      // ready on the last allowed fetch cycle
        run_instr(6'd18, 0, TMO - 1);     // ready on the last allowed store cycle

        // Reset in the middle of a store access
        step("rmw_fetch", 6'd0, 1'b1, 1'b0, fetch_exp(1'b1));
        step("rmw_decode", 6'd18, 1'b0, 1'b0, idle(4'd1));
        e = idle(4'd6);
        e.asrc = 2'b01;
        e.aop = 6'd6;
        step("rmw_addr", 6'd0, 1'b0, 1'b0, e);
        e = idle(4'd8);
        e.req = 1'b1;
        e.mwr = 2'b11;
        step("rmw_memwr_rst", 6'd0, 1'b0, 1'b1, e);
        step("rmw_after_reset", 6'd0, 1'b0, 1'b0, fetch_exp(1'b0));

        for (int n = 0; n < 80; n++) begin
            op = legal_ops[$urandom_range(0, 18)];
`ifndef ILLEGAL_TRAP_EN
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (cls_of(op) != C_X) op = 6'($urandom);
            end
`endif
            run_instr(op, ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3));
        end

        run_timeout(6'd0);                // fetch starved
        run_timeout(6'd20);               // LB data starved
        run_timeout(6'd16);               // SB data starved

        // Unlisted opcode 111000
        run_instr(6'b111000, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        e = idle(4'd11);
        e.berr = 1'b1;
        step("trap_in_reset", 6'd0, 1'b0, 1'b1, e);
        step("trap_after_reset", 6'd0, 1'b0, 1'b0, fetch_exp(1'b0));
`else
        run_instr(6'd7, 0, 0);            // next instruction proceeds normally
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
